phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_if.sv | 27 ++
 rtl/phase_sequencer.sv | 98 +++++++++
 tb/tb_phase_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Signal bundle between the slow-clock source/controller and the phase sequencer.
// The master drives slow_clk/enable/stall; the sequencer (slave) returns pulses, phase and counters.
interface phase_sequencer_if #(
    parameter int CNT_W   = 32,
    parameter int STALL_W = 16
);
    logic               slow_clk;
    logic               enable;
    logic               stall;
    logic               rise_pulse;
    logic               fall_pulse;
    logic [2:0]         phase;
    logic [3:0]         strobe;
    logic               busy;
    logic [CNT_W-1:0]   cycle_count;
    logic [STALL_W-1:0] stall_count;

    modport master (
        output slow_clk, enable, stall,
        input  rise_pulse, fall_pulse, phase, strobe, busy, cycle_count, stall_count
    );

    modport slave (
        input  slow_clk, enable, stall,
        output rise_pulse, fall_pulse, phase, strobe, busy, cycle_count, stall_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer stepped by rising edges of a divided clock that is
// sampled as data on clkin; counts completed instruction cycles and stall holds.
module phase_sequencer #(
    parameter int CNT_W   = 32,
    parameter int STALL_W = 16
) (
    input  logic              clkin,
    input  logic              reset,
    phase_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4
    } phase_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [STALL_W-1:0] STALL_ONE = 1;

    phase_t             phase_q;
    logic               slow_q;
    logic               primed_q;
    logic               rise_q;
    logic               fall_q;
    logic [3:0]         strobe_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [STALL_W-1:0] stall_q;
    logic               rise_d;
    logic               fall_d;

    // primed_q masks the first edge after reset release so a high slow_clk is not seen as a rise.
    assign rise_d =  bus.slow_clk & ~slow_q & primed_q;
    assign fall_d = ~bus.slow_clk &  slow_q & primed_q;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            slow_q   <= 1'b0;
            primed_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            strobe_q <= 4'b0000;
            phase_q  <= IDLE;
            cycle_q  <= '0;
            stall_q  <= '0;
        end else begin
            slow_q   <= bus.slow_clk;
            primed_q <= 1'b1;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            strobe_q <= 4'b0000;
            if (rise_d) begin
                if (phase_q == IDLE) begin
                    if (bus.enable && !bus.stall) begin
                        phase_q  <= FETCH;
                        strobe_q <= 4'b0001;
                    end
                end else if (bus.stall) begin
                    if (stall_q != '1) stall_q <= stall_q + STALL_ONE;
                end else begin
                    case (phase_q)
                        FETCH: begin
                            phase_q  <= DECODE;
                            strobe_q <= 4'b0010;
                        end
                        DECODE: begin
                            phase_q  <= EXECUTE;
                            strobe_q <= 4'b0100;
                        end
                        EXECUTE: begin
                            phase_q  <= WRITEBACK;
                            strobe_q <= 4'b1000;
                        end
                        WRITEBACK: begin
                            if (cycle_q != '1) cycle_q <= cycle_q + CNT_ONE;
                            if (bus.enable) begin
                                phase_q  <= FETCH;
                                strobe_q <= 4'b0001;
                            end else begin
                                phase_q  <= IDLE;
                            end
                        end
                        default: phase_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.phase       = phase_q;
    assign bus.strobe      = strobe_q;
    assign bus.busy        = (phase_q != IDLE);
    assign bus.cycle_count = cycle_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios with literal expectations
// plus randomized slow_clk/enable/stall/reset checked every cycle against a behavioural model.
module tb_phase_sequencer;
    localparam int CNT_W   = 4;
    localparam int STALL_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int STL_MAX = (1 << STALL_W) - 1;

    logic clkin;
    logic reset;
    int   nCompared;
    int   nMismatched;
    bit   cmpEn;

    phase_sequencer_if #(.CNT_W(CNT_W), .STALL_W(STALL_W)) ifc ();

    phase_sequencer #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Behavioural model: phases are plain integers 0..4, counters are ints clamped at their maxima.
    bit mPrev, mPrimed, mRise, mFall;
    int mPhase, mStrobe, mCyc, mStl;
    wire mRiseEv = ifc.slow_clk && !mPrev && mPrimed;
    wire mFallEv = !ifc.slow_clk && mPrev && mPrimed;

    always @(posedge clkin or negedge reset) begin
        if (!reset) begin
            mPrev <= 0; mPrimed <= 0; mRise <= 0; mFall <= 0;
            mPhase <= 0; mStrobe <= 0; mCyc <= 0; mStl <= 0;
        end else begin
            mPrev   <= ifc.slow_clk;
            mPrimed <= 1;
            mRise   <= mRiseEv;
            mFall   <= mFallEv;
            mStrobe <= 0;
            if (mRiseEv) begin
                if (mPhase == 0) begin
                    if (ifc.enable && !ifc.stall) begin
                        mPhase  <= 1;
                        mStrobe <= 1;
                    end
                end else if (ifc.stall) begin
                    mStl <= (mStl >= STL_MAX) ? STL_MAX : mStl + 1;
                end else if (mPhase == 4) begin
                    mCyc    <= (mCyc >= CNT_MAX) ? CNT_MAX : mCyc + 1;
                    mPhase  <= ifc.enable ? 1 : 0;
                    mStrobe <= ifc.enable ? 1 : 0;
                end else begin
                    mPhase  <= mPhase + 1;
                    mStrobe <= 1 << mPhase;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clkin) begin
        if (cmpEn) begin
            checkOutput("model_rise",   ifc.rise_pulse,  mRise);
            checkOutput("model_fall",   ifc.fall_pulse,  mFall);
            checkOutput("model_phase",  ifc.phase,       mPhase);
            checkOutput("model_strobe", ifc.strobe,      mStrobe);
            checkOutput("model_busy",   ifc.busy,        mPhase != 0);
            checkOutput("model_cycle",  ifc.cycle_count, mCyc);
            checkOutput("model_stall",  ifc.stall_count, mStl);
        end
    end

    // Raise slow_clk with the given run/hold request; returns at the negedge where the pulses are visible.
    task automatic applyStimulus(input logic e, input logic s);
        ifc.enable   = e;
        ifc.stall    = s;
        ifc.slow_clk = 1'b1;
        @(negedge clkin);
    endtask

    task automatic finishPeriod();
        repeat (3) @(negedge clkin);
        ifc.slow_clk = 1'b0;
        repeat (4) @(negedge clkin);
    endtask

    task automatic runRises(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(e, 1'b0);
            finishPeriod();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rise"},   ifc.rise_pulse,  0);
        checkOutput({tag, "_fall"},   ifc.fall_pulse,  0);
        checkOutput({tag, "_phase"},  ifc.phase,       0);
        checkOutput({tag, "_strobe"}, ifc.strobe,      0);
        checkOutput({tag, "_busy"},   ifc.busy,        0);
        checkOutput({tag, "_cycle"},  ifc.cycle_count, 0);
        checkOutput({tag, "_stall"},  ifc.stall_count, 0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        cmpEn       = 0;
        reset       = 1'b0;
        ifc.slow_clk = 1'b0;
        ifc.enable   = 1'b0;
        ifc.stall    = 1'b0;
        repeat (3) @(negedge clkin);
        cmpEn = 1;
        checkAllZero("reset");

        // Release with slow_clk already high: no rise, first pulse is the fall.
        ifc.slow_clk = 1'b1;
        @(negedge clkin);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            checkOutput("no_rise_after_release", ifc.rise_pulse, 0);
        end
        ifc.slow_clk = 1'b0;
        @(negedge clkin);
        checkOutput("first_fall", ifc.fall_pulse, 1);
        @(negedge clkin);
        checkOutput("fall_one_cycle", ifc.fall_pulse, 0);
        repeat (3) @(negedge clkin);

        // Normal run through all four phases.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("run_rise",   ifc.rise_pulse, 1);
            checkOutput("run_phase",  ifc.phase, k);
            checkOutput("run_strobe", ifc.strobe, 1 << (k - 1));
            finishPeriod();
        end
        checkOutput("cycle_before_exit", ifc.cycle_count, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("refetch_phase",  ifc.phase, 1);
        checkOutput("refetch_strobe", ifc.strobe, 1);
        checkOutput("cycle_first",    ifc.cycle_count, 1);
        finishPeriod();

        // Stall three rises in EXECUTE.
        runRises(2, 1'b1);
        checkOutput("at_execute", ifc.phase, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("stall_phase",  ifc.phase, 3);
            checkOutput("stall_strobe", ifc.strobe, 0);
            finishPeriod();
        end
        checkOutput("stall_count3", ifc.stall_count, 3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("after_stall_phase",  ifc.phase, 4);
        checkOutput("after_stall_strobe", ifc.strobe, 8);
        finishPeriod();

        // Drop enable during DECODE: sequence completes then idles.
        runRises(2, 1'b1);
        checkOutput("at_decode", ifc.phase, 2);
        runRises(2, 1'b0);
        checkOutput("drop_wb", ifc.phase, 4);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drop_idle_busy",   ifc.busy, 0);
        checkOutput("drop_idle_strobe", ifc.strobe, 0);
        checkOutput("drop_idle_cycle",  ifc.cycle_count, 3);
        finishPeriod();

        // Stall in IDLE neither leaves IDLE nor counts.
        applyStimulus(1'b1, 1'b1);
        checkOutput("idle_stall_phase", ifc.phase, 0);
        checkOutput("idle_stall_count", ifc.stall_count, 3);
        finishPeriod();

        // Reach WRITEBACK with cycle_count=5, then reset asynchronously.
        runRises(12, 1'b1);
        checkOutput("wb5_phase", ifc.phase, 4);
        checkOutput("wb5_cycle", ifc.cycle_count, 5);
        @(negedge clkin);
        #2 reset = 1'b0;
        #1 checkAllZero("async_reset");
        @(negedge clkin);
        reset = 1'b1;
        repeat (2) @(negedge clkin);

        // Saturate cycle_count.
        runRises(68, 1'b1);
        checkOutput("cycle_saturated", ifc.cycle_count, CNT_MAX);

        // Randomized traffic, including occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clkin);
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(499) == 0) begin
                #2 reset = 1'b0;
            end
            if ($urandom_range(2) == 0) ifc.slow_clk = ~ifc.slow_clk;
            ifc.enable = ($urandom_range(3) != 0);
            ifc.stall  = ($urandom_range(3) == 0);
        end
        @(negedge clkin);
        reset = 1'b1;
        repeat (2) @(negedge clkin);
        cmpEn = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
